// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver feeding a little-endian 64-bit word assembler that writes
// program words into instruction memory until the terminator word arrives.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 21,
  parameter int          ADDR_W       = 8,
  parameter logic [63:0] TERM_WORD    = 64'h0000000000000FFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              uart_rx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic              programmed_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              frame_err_o,
  output logic              ovf_o
);

  localparam int              TW     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0]   T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]   T_FULL = TW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAITH = 3'd4;

  logic              r_rx_s1, r_rx_s2, r_rx_d;
  logic [2:0]        r_state;
  logic [TW-1:0]     r_timer;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [2:0]        r_byte_idx;
  logic [63:0]       r_word;
  logic [ADDR_W:0]   r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic              r_prog;
  logic              r_ferr;
  logic              r_ovf;

  logic        w_fall;
  logic        w_stop_tick;
  logic        w_byte_vld;
  logic        w_word_done;
  logic [63:0] w_word_full;

  assign w_fall      = r_rx_d & ~r_rx_s2;
  assign w_stop_tick = (r_state == S_STOP) && (r_timer == T_FULL);
  assign w_byte_vld  = w_stop_tick && r_rx_s2;
  assign w_word_done = w_byte_vld && (r_byte_idx == 3'd7);
  // Completed word including the byte arriving this cycle in the top slot.
  assign w_word_full = {r_shift, r_word[55:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx_i;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_ferr    <= 1'b0;
    end else begin
      r_ferr <= w_stop_tick && !r_rx_s2;
      case (r_state)
        S_IDLE: begin
          if (!r_prog && w_fall) begin
            r_state <= S_START;
            r_timer <= '0;
          end
        end
        S_START: begin
          if (r_timer == T_HALF) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DATA: begin
          if (r_timer == T_FULL) begin
            r_timer            <= '0;
            r_shift[r_bit_idx] <= r_rx_s2;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_STOP: begin
          if (r_timer == T_FULL) begin
            r_timer <= '0;
            r_state <= r_rx_s2 ? S_IDLE : S_WAITH;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAITH: begin
          if (r_rx_s2) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word completion is decided on the last byte's stop sample so the write
  // strobe or the done flag is visible on the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_idx <= '0;
      r_word     <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_prog     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_byte_vld) begin
        r_word[8*r_byte_idx +: 8] <= r_shift;
        r_byte_idx                <= r_byte_idx + 3'd1;
        if (w_word_done) begin
          if (w_word_full == TERM_WORD) begin
            r_prog <= 1'b1;
          end else if (!r_cnt[ADDR_W]) begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt[ADDR_W-1:0];
            r_wdata <= w_word_full;
            r_cnt   <= r_cnt + 1'b1;
          end else begin
            r_ovf  <= 1'b1;
            r_prog <= 1'b1;
          end
        end
      end
    end
  end

  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign programmed_o = r_prog;
  assign word_cnt_o   = r_cnt;
  assign frame_err_o  = r_ferr;
  assign ovf_o        = r_ovf;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench: two loaders (large and 4-word memory) share one serial
// line; a byte-level reference model feeds write scoreboards.
module tb_uart_prog_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  always #200 clk = ~clk;

  localparam logic [63:0] TERM = 64'h0000000000000FFF;

  logic       we_a, prog_a, ferr_a, ovf_a;
  logic [7:0] addr_a;
  logic [8:0] cnt_a;
  logic [63:0] wd_a;
  logic       we_b, prog_b, ferr_b, ovf_b;
  logic [1:0] addr_b;
  logic [2:0] cnt_b;
  logic [63:0] wd_b;

  uart_prog_loader #(.CLKS_PER_BIT(21), .ADDR_W(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(rx),
    .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_wdata_o(wd_a),
    .programmed_o(prog_a), .word_cnt_o(cnt_a), .frame_err_o(ferr_a), .ovf_o(ovf_a));

  uart_prog_loader #(.CLKS_PER_BIT(21), .ADDR_W(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(rx),
    .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_wdata_o(wd_b),
    .programmed_o(prog_b), .word_cnt_o(cnt_b), .frame_err_o(ferr_b), .ovf_o(ovf_b));

  int total = 0;
  int bad   = 0;

  // reference model, index 0 = dut_a, 1 = dut_b
  int          m_cap [2] = '{256, 4};
  int          m_cnt [2];
  int          m_nb  [2];
  int          m_ferr[2];
  bit          m_prog[2];
  bit          m_ovf [2];
  logic [63:0] m_word[2];
  logic [71:0] q0[$];
  logic [71:0] q1[$];
  int          seen_ferr_a = 0;
  int          seen_ferr_b = 0;
  logic [71:0] e_a, e_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    for (int m = 0; m < 2; m++) begin
      if (m_prog[m]) continue;
      if (!good) begin
        m_ferr[m]++;
        continue;
      end
      m_word[m][8*m_nb[m] +: 8] = b;
      m_nb[m]++;
      if (m_nb[m] == 8) begin
        m_nb[m] = 0;
        if (m_word[m] == TERM) m_prog[m] = 1'b1;
        else if (m_cnt[m] < m_cap[m]) begin
          if (m == 0) q0.push_back({8'(m_cnt[m]), m_word[m]});
          else        q1.push_back({8'(m_cnt[m]), m_word[m]});
          m_cnt[m]++;
        end else begin
          m_ovf[m]  = 1'b1;
          m_prog[m] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (we_a) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_a_unexpected: got addr %h data %h expected no write", addr_a, wd_a);
      end else begin
        e_a = q0.pop_front();
        chk("wr_a_addr", 64'(addr_a), 64'(e_a[71:64]));
        chk("wr_a_data", wd_a, e_a[63:0]);
      end
    end
    if (we_b) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_b_unexpected: got addr %h data %h expected no write", addr_b, wd_b);
      end else begin
        e_b = q1.pop_front();
        chk("wr_b_addr", 64'(addr_b), 64'(e_b[71:64]));
        chk("wr_b_data", wd_b, e_b[63:0]);
      end
    end
    if (ferr_a) seen_ferr_a++;
    if (ferr_b) seen_ferr_b++;
  end

  task automatic send_byte(input logic [7:0] b, input int stretch, input bit stop, input bit chk_prog);
    model_byte(b, stop);
    @(posedge clk); #1;
    rx = 1'b0;
    #(8400 + stretch);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #8400;
    end
    rx = stop;
    if (chk_prog) chk("prog_before_stop", 64'(prog_a), 64'd0);
    #8400;
    if (chk_prog) chk("prog_after_stop", 64'(prog_a), 64'd1);
    rx = 1'b1;
    #16800;
  endtask

  task automatic send_word(input logic [63:0] w, input int stretch);
    for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8], stretch, 1'b1, 1'b0);
  endtask

  function automatic logic [63:0] rnd_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (w == TERM) w = w ^ 64'h1;
    return w;
  endfunction

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_a"}, {we_a, addr_a, wd_a[31:0], prog_a, cnt_a, ferr_a, ovf_a}, 64'd0);
    chk({nm, "_a_hi"}, 64'(wd_a[63:32]), 64'd0);
    chk({nm, "_b"}, {we_b, addr_b, wd_b[31:0], prog_b, cnt_b, ferr_b, ovf_b}, 64'd0);
    chk({nm, "_b_hi"}, 64'(wd_b[63:32]), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    rx    = 1'b1;
    #1000;
    check_outputs_zero("rst_during");
    rst_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_nb[m] = 0; m_prog[m] = 1'b0; m_ovf[m] = 1'b0; m_word[m] = '0;
    end
    q0.delete();
    q1.delete();
    #2000;
    check_outputs_zero("rst_after");
  endtask

  task automatic checkpoint(input string nm);
    #4000;
    chk({nm, " cnt_a"},  64'(cnt_a),  64'(m_cnt[0]));
    chk({nm, " cnt_b"},  64'(cnt_b),  64'(m_cnt[1]));
    chk({nm, " prog_a"}, 64'(prog_a), 64'(m_prog[0]));
    chk({nm, " prog_b"}, 64'(prog_b), 64'(m_prog[1]));
    chk({nm, " ovf_a"},  64'(ovf_a),  64'(m_ovf[0]));
    chk({nm, " ovf_b"},  64'(ovf_b),  64'(m_ovf[1]));
    chk({nm, " ferr_a"}, 64'(seen_ferr_a), 64'(m_ferr[0]));
    chk({nm, " ferr_b"}, 64'(seen_ferr_b), 64'(m_ferr[1]));
    chk({nm, " pend_a"}, 64'(q0.size()), 64'd0);
    chk({nm, " pend_b"}, 64'(q1.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] t;
    t = TERM;
    m_ferr[0] = 0;
    m_ferr[1] = 0;

    do_reset();
    send_word(64'h13, 0);
    checkpoint("single_word");

    do_reset();
    send_word(64'h00500093_00A00113, 0);
    send_word(64'h002081B3_00000013, 0);
    for (int i = 0; i < 7; i++) send_byte(t[8*i +: 8], 0, 1'b1, 1'b0);
    send_byte(t[63:56], 0, 1'b1, 1'b1);
    send_byte(8'h55, 0, 1'b0, 1'b0);
    send_word(rnd_word(), 0);
    checkpoint("terminator");

    do_reset();
    @(posedge clk); #1;
    rx = 1'b0;
    #1600;
    rx = 1'b1;
    #16800;
    send_byte(8'hA5, 1000, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1000, 1'b1, 1'b0);
    checkpoint("glitch_stretch");

    for (int i = 0; i < 2; i++) send_byte(8'($urandom), 0, 1'b1, 1'b0);
    send_byte(8'($urandom), 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0, 1'b1, 1'b0);
    checkpoint("frame_err");

    do_reset();
    for (int k = 0; k < 5; k++) send_word(rnd_word(), int'($urandom_range(0, 1000)));
    checkpoint("overflow");
    send_word(TERM, 0);
    checkpoint("overflow_term");

    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0, 1'b1, 1'b0);
    do_reset();
    @(posedge clk); #1;
    rx = 1'b0;
    #33600;
    do_reset();
    send_word(rnd_word(), int'($urandom_range(0, 1000)));
    checkpoint("reset_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Device-side end of the UART program-download link: 8N1 serial receiver plus word assembler.
- Collects little-endian bytes into 64-bit program words and writes each word to instruction memory at incrementing word addresses.
- Terminator word 64'h0000_0000_0000_0FFF ends the download, is not written, and sets programmed_o; the top level releases the core from reset on programmed_o.

Parameters:
CLKS_PER_BIT, 21, clock cycles per UART bit (8400 ns bit period / 400 ns clock)
ADDR_W, 8, word-address width of instruction memory
TERM_WORD, 64'h0000000000000FFF, end-of-program marker

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
uart_rx_i  in  1  serial line, idle high, LSB first, 8N1
mem_we_o  out  1  one-cycle write strobe
mem_addr_o  out  ADDR_W  word address of current write
mem_wdata_o  out  64  assembled word
programmed_o  out  1  sticky; download complete
word_cnt_o  out  ADDR_W+1  words written so far
frame_err_o  out  1  one-cycle pulse on bad stop bit
ovf_o  out  1  sticky; memory full before terminator

Behaviour:
- Reset: rst_ni low asynchronously clears all state. After reset:
  - all outputs are 0;
  - FSM is IDLE;
  - byte index is 0;
  - address is 0.
- Reset mid-frame or mid-word discards partial data.
- uart_rx_i passes through a 2-flop synchronizer. Its reset value is 1.
- RX FSM:
  - IDLE: a synchronized falling edge (1 then 0) goes to START and clears the bit-timer.
  - START: at timer = CLKS_PER_BIT/2 - 1 (integer division), sample the line.
    - Low: go to DATA, timer = 0, bit index = 0.
    - High: false start, return to IDLE.
  - DATA: at timer = CLKS_PER_BIT-1, sample into shift[bit index] (LSB first). After bit 7, go to STOP.
  - STOP: at timer = CLKS_PER_BIT-1, sample the line.
    - High: byte valid for one cycle, go to IDLE.
    - Low: pulse frame_err_o, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronized line is 1, then go to IDLE.
- Sampling rule: mid-bit sampling relative to the detected start edge. This must tolerate a start bit stretched up to CLKS_PER_BIT/2 cycles longer than nominal, since the host inserts slack after the start bit.
- Word assembly:
  - Each valid byte writes word[8*idx +: 8], with idx running 0..7.
  - When idx = 7, the word is complete and idx returns to 0.
- Word completion, the cycle after the last byte:
  - Word == TERM_WORD: no write; programmed_o <= 1.
  - Otherwise, if address is below 2^ADDR_W: mem_we_o = 1 for one cycle with mem_addr_o = address and mem_wdata_o = word; address and word_cnt_o increment.
  - Otherwise: ovf_o <= 1 and programmed_o <= 1, with no write.
- mem_addr_o and mem_wdata_o hold their last value between strobes.
- Once programmed_o = 1, all further RX is ignored and the FSM stays IDLE. No writes and no frame_err_o until reset.
- A frame error leaves idx unchanged; the next good byte fills the same slot.
- Latency: the stop-bit sample produces the byte-valid flag in the same cycle. mem_we_o or programmed_o asserts 1 cycle later.

Test Plan:
- Bytes 13 00 00 00 00 00 00 00 -> one mem_we_o pulse, addr 0, wdata 64'h13, word_cnt_o = 1, programmed_o = 0.
- Two words (64'h00500093_00A00113, 64'h002081B3_00000013), then FF 0F 00 00 00 00 00 00 -> writes at addr 0 and 1 with exact data, no write for the terminator, programmed_o = 1 one cycle after the 8th terminator byte's stop sample, word_cnt_o = 2.
- Each start bit stretched by +1000 ns (2.5 clocks) at CLKS_PER_BIT = 21 -> all bytes decoded correctly, no frame_err_o.
- A 4-clock low glitch on an idle line -> no byte, FSM back to IDLE, a following byte A5 decodes as A5.
- Byte with stop bit driven 0 -> single frame_err_o pulse, no byte accepted, idx unchanged. The line then goes high and the next byte fills the same slot.
- ADDR_W = 2: five non-terminator words -> four writes (addr 0..3). The fifth sets ovf_o = 1 and programmed_o = 1 with no write.
- Reset pulse after 3 bytes of a word -> outputs 0. A new full 8-byte word then writes at addr 0 with only the new bytes.
